// File: rtl/output_bitrate_meter.sv
// Egress bitrate tap: pass-through datapath that parses IO-queue headers and
// reports per-MAC-port and total bit/s once per sampling window.
module output_bitrate_meter #(
    parameter int                    DATA_WIDTH         = 64,
    parameter int                    CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM = CTRL_WIDTH'(8'hff)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic [2:0]            sample_sel,
    output logic [31:0]           q0_bitrate,
    output logic [31:0]           q1_bitrate,
    output logic [31:0]           q2_bitrate,
    output logic [31:0]           q3_bitrate,
    output logic [31:0]           total_bitrate,
    output logic                  rate_valid
);

    typedef enum logic {P_HDR, P_PAYLOAD} parse_t;
    typedef enum logic [1:0] {W_COUNT, W_MULT, W_SUM} win_t;

    assign out_data = in_data;
    assign out_ctrl = in_ctrl;
    assign out_wr   = in_wr;
    assign in_rdy   = out_rdy;

    // ---------------- header parser ----------------
    parse_t      r_pstate;
    parse_t      w_pnext;
    logic        r_hdr_seen;
    logic [3:0]  r_dst;
    logic [15:0] r_len;

    logic [15:0] w_hdr_dst;
    logic        w_ctrl_nz;
    logic        w_is_ioq;
    logic        w_hdr_load;
    logic        w_eop;
    logic [3:0]  w_add;
    logic        w_unused;

    assign w_hdr_dst  = in_data[DATA_WIDTH-1 -: 16];
    assign w_ctrl_nz  = |in_ctrl;
    assign w_is_ioq   = (in_ctrl == IO_QUEUE_STAGE_NUM);
    assign w_hdr_load = in_wr && (r_pstate == P_HDR) && w_is_ioq;
    assign w_eop      = in_wr && (r_pstate == P_PAYLOAD) && w_ctrl_nz;
    assign w_unused   = ^{w_hdr_dst[15:8], w_hdr_dst[7], w_hdr_dst[5], w_hdr_dst[3],
                          w_hdr_dst[1], in_data[DATA_WIDTH-17:16]};

    // MAC port i is dst bit 2i; CPU (odd) bits are not kept
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            w_add[i] = w_eop && r_hdr_seen && r_dst[i];
        end
    end

    always_comb begin
        w_pnext = r_pstate;
        case (r_pstate)
            P_HDR:     if (in_wr && !w_ctrl_nz) w_pnext = P_PAYLOAD;
            P_PAYLOAD: if (in_wr && w_ctrl_nz)  w_pnext = P_HDR;
            default:   w_pnext = P_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pstate   <= P_HDR;
            r_hdr_seen <= 1'b0;
            r_dst      <= '0;
            r_len      <= '0;
        end else begin
            r_pstate <= w_pnext;
            if (w_hdr_load) begin
                r_dst      <= {w_hdr_dst[6], w_hdr_dst[4], w_hdr_dst[2], w_hdr_dst[0]};
                r_len      <= in_data[15:0];
                r_hdr_seen <= 1'b1;
            end else if (w_eop) begin
                r_hdr_seen <= 1'b0;
            end
        end
    end

    // ---------------- window control ----------------
    win_t        r_wstate;
    win_t        w_wnext;
    logic [19:0] r_cnt;
    logic [19:0] r_period;
    logic [26:0] r_scale;
    logic [19:0] w_sel_period;
    logic [26:0] w_sel_scale;
    logic        w_snap;

    always_comb begin
        case (sample_sel)
            3'd1:    begin w_sel_period = 20'd10;     w_sel_scale = 27'd100_000_000; end
            3'd2:    begin w_sel_period = 20'd100;    w_sel_scale = 27'd10_000_000;  end
            3'd3:    begin w_sel_period = 20'd1000;   w_sel_scale = 27'd1_000_000;   end
            3'd4:    begin w_sel_period = 20'd10000;  w_sel_scale = 27'd100_000;     end
            3'd5:    begin w_sel_period = 20'd100000; w_sel_scale = 27'd10_000;      end
            default: begin w_sel_period = 20'd1000000; w_sel_scale = 27'd1_000;      end
        endcase
    end

    assign w_snap = (r_wstate == W_COUNT) && (r_cnt == r_period - 20'd1);

    always_comb begin
        w_wnext = r_wstate;
        case (r_wstate)
            W_COUNT: if (w_snap) w_wnext = W_MULT;
            W_MULT:  w_wnext = W_SUM;
            W_SUM:   w_wnext = W_COUNT;
            default: w_wnext = W_COUNT;
        endcase
    end

    // ---------------- accumulators and rate math ----------------
    logic [31:0] r_acc  [4];
    logic [31:0] r_snap [4];
    logic [31:0] r_q    [4];
    logic [31:0] r_total;
    logic        r_rate_valid;

    logic [32:0] w_acc_wide [4];
    logic [31:0] w_acc_sum  [4];
    logic [58:0] w_prod     [4];
    logic [31:0] w_q_sat    [4];
    logic [33:0] w_total_wide;
    logic [31:0] w_total_sat;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            w_acc_wide[i] = {1'b0, r_acc[i]} + {17'b0, r_len};
            w_acc_sum[i]  = w_acc_wide[i][32] ? '1 : w_acc_wide[i][31:0];
            w_prod[i]     = {27'b0, r_snap[i]} * {32'b0, r_scale};
            w_q_sat[i]    = (|w_prod[i][58:32]) ? '1 : w_prod[i][31:0];
        end
        w_total_wide = {2'b0, r_q[0]} + {2'b0, r_q[1]} + {2'b0, r_q[2]} + {2'b0, r_q[3]};
        w_total_sat  = (|w_total_wide[33:32]) ? '1 : w_total_wide[31:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate     <= W_COUNT;
            r_cnt        <= '0;
            r_period     <= 20'd1000000;
            r_scale      <= 27'd1_000;
            r_total      <= '0;
            r_rate_valid <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_acc[i]  <= '0;
                r_snap[i] <= '0;
                r_q[i]    <= '0;
            end
        end else begin
            r_wstate     <= w_wnext;
            r_cnt        <= w_snap ? '0 : r_cnt + 20'd1;
            r_rate_valid <= (r_wstate == W_SUM);
            // window parameters only change at a window boundary
            if (r_cnt == '0) begin
                r_period <= w_sel_period;
                r_scale  <= w_sel_scale;
            end
            // an EOP on the snapshot cycle seeds the next window's accumulator
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_snap) begin
                    r_snap[i] <= r_acc[i];
                    r_acc[i]  <= w_add[i] ? {16'b0, r_len} : '0;
                end else if (w_add[i]) begin
                    r_acc[i] <= w_acc_sum[i];
                end
                if (r_wstate == W_MULT) r_q[i] <= w_q_sat[i];
            end
            if (r_wstate == W_SUM) r_total <= w_total_sat;
        end
    end

    assign q0_bitrate    = r_q[0];
    assign q1_bitrate    = r_q[1];
    assign q2_bitrate    = r_q[2];
    assign q3_bitrate    = r_q[3];
    assign total_bitrate = r_total;
    assign rate_valid    = r_rate_valid;

endmodule

// File: tb/tb_output_bitrate_meter.sv
// Directed self-checking bench for output_bitrate_meter.
module tb_output_bitrate_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic [2:0]  sample_sel;
    logic [31:0] q0_bitrate, q1_bitrate, q2_bitrate, q3_bitrate, total_bitrate;
    logic        rate_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    logic ok;

    output_bitrate_meter #(.DATA_WIDTH(64)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .sample_sel(sample_sel),
        .q0_bitrate(q0_bitrate), .q1_bitrate(q1_bitrate), .q2_bitrate(q2_bitrate),
        .q3_bitrate(q3_bitrate), .total_bitrate(total_bitrate), .rate_valid(rate_valid)
    );

    always #5 clk = ~clk;

    // cyc = k+1 just after edge k of the current post-reset window sequence
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    task automatic do_reset;
        reset = 1'b1; in_wr = 1'b0; in_ctrl = '0; in_data = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] c, input logic [63:0] d);
        in_ctrl = c; in_data = d; in_wr = 1'b1;
        @(posedge clk); #1;
        in_wr = 1'b0; in_ctrl = '0; in_data = '0;
    endtask

    task automatic send_pkt(input logic [15:0] dst, input logic [15:0] len, input int npay);
        send_word(8'hff, {dst, 32'h0, len});
        for (int k = 0; k < npay; k++) send_word(8'h00, {32'hdeadbeef, 32'(k)});
        send_word(8'h01, 64'hfeedface_00000000);
    endtask

    task automatic wait_valid(input int maxc, output logic found);
        found = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (rate_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; out_rdy = 1'b0; sample_sel = 3'd3;
        in_data = 64'h0123_4567_89ab_cdef; in_ctrl = 8'h5a; in_wr = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if ({out_data, out_ctrl, out_wr, in_rdy} !== {64'h0123_4567_89ab_cdef, 8'h5a, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_passthru got data=%h ctrl=%h wr=%b rdy=%b need 0123456789abcdef 5a 1 0",
                     out_data, out_ctrl, out_wr, in_rdy);
        end
        out_rdy = 1'b1;
        do_reset();
        n_checks++;
        if ({q0_bitrate, q1_bitrate, q2_bitrate, q3_bitrate, total_bitrate, rate_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_values got q0=%0d q1=%0d q2=%0d q3=%0d tot=%0d rv=%b need all 0",
                     q0_bitrate, q1_bitrate, q2_bitrate, q3_bitrate, total_bitrate, rate_valid);
        end
    endtask

    task automatic test_unicast;
        sample_sel = 3'd3;
        do_reset();
        send_pkt(16'h0004, 16'd60, 1);
        wait_valid(2000, ok);
        n_checks++;
        if (!ok || cyc != 1002) begin
            n_fail++; $display("FAIL uni_timing got ok=%b cyc=%0d need cyc=1002", ok, cyc);
        end
        n_checks++;
        if ({q0_bitrate, q1_bitrate, q2_bitrate, q3_bitrate, total_bitrate} !==
            {32'd0, 32'd60_000_000, 32'd0, 32'd0, 32'd60_000_000}) begin
            n_fail++;
            $display("FAIL uni_rates got q0=%0d q1=%0d q2=%0d q3=%0d tot=%0d need 0 60000000 0 0 60000000",
                     q0_bitrate, q1_bitrate, q2_bitrate, q3_bitrate, total_bitrate);
        end
        @(posedge clk); #1;
        n_checks++;
        if (rate_valid !== 1'b0) begin
            n_fail++; $display("FAIL uni_pulse_width got rv=%b need 0", rate_valid);
        end
    endtask

    task automatic test_multicast;
        sample_sel = 3'd3;
        do_reset();
        send_pkt(16'h0005, 16'd100, 2);
        wait_valid(2000, ok);
        n_checks++;
        if (!ok || cyc != 1002) begin
            n_fail++; $display("FAIL mc_timing got ok=%b cyc=%0d need cyc=1002", ok, cyc);
        end
        n_checks++;
        if ({q0_bitrate, q1_bitrate, q2_bitrate, q3_bitrate, total_bitrate} !==
            {32'd100_000_000, 32'd100_000_000, 32'd0, 32'd0, 32'd200_000_000}) begin
            n_fail++;
            $display("FAIL mc_rates got q0=%0d q1=%0d q2=%0d q3=%0d tot=%0d need 100000000 100000000 0 0 200000000",
                     q0_bitrate, q1_bitrate, q2_bitrate, q3_bitrate, total_bitrate);
        end
        // window 1: CPU-only packet, then a packet with only a foreign module header
        send_pkt(16'h0002, 16'd80, 1);
        send_word(8'h10, 64'h0001_0000_0000_0040);
        send_word(8'h00, 64'h0);
        send_word(8'h01, 64'h0);
        repeat (500) @(posedge clk);
        #1;
        n_checks++;
        if ({q0_bitrate, q1_bitrate, total_bitrate, rate_valid} !==
            {32'd100_000_000, 32'd100_000_000, 32'd200_000_000, 1'b0}) begin
            n_fail++;
            $display("FAIL mc_hold got q0=%0d q1=%0d tot=%0d rv=%b need 100000000 100000000 200000000 0",
                     q0_bitrate, q1_bitrate, total_bitrate, rate_valid);
        end
        wait_valid(2000, ok);
        n_checks++;
        if (!ok || cyc != 2002) begin
            n_fail++; $display("FAIL cpu_timing got ok=%b cyc=%0d need cyc=2002", ok, cyc);
        end
        n_checks++;
        if ({q0_bitrate, q1_bitrate, q2_bitrate, q3_bitrate, total_bitrate} !== '0) begin
            n_fail++;
            $display("FAIL cpu_rates got q0=%0d q1=%0d q2=%0d q3=%0d tot=%0d need all 0",
                     q0_bitrate, q1_bitrate, q2_bitrate, q3_bitrate, total_bitrate);
        end
    endtask

    task automatic test_saturation;
        sample_sel = 3'd1;
        do_reset();
        send_pkt(16'h0001, 16'd60, 1);
        wait_valid(100, ok);
        n_checks++;
        if (!ok || cyc != 12) begin
            n_fail++; $display("FAIL sat1_timing got ok=%b cyc=%0d need cyc=12", ok, cyc);
        end
        n_checks++;
        if ({q0_bitrate, q1_bitrate, total_bitrate} !== {32'hffff_ffff, 32'd0, 32'hffff_ffff}) begin
            n_fail++;
            $display("FAIL sat1_rates got q0=%h q1=%h tot=%h need ffffffff 00000000 ffffffff",
                     q0_bitrate, q1_bitrate, total_bitrate);
        end
        do_reset();
        send_pkt(16'h0001, 16'd60, 1);
        send_pkt(16'h0004, 16'd60, 1);
        send_pkt(16'h0010, 16'd60, 1);
        wait_valid(100, ok);
        n_checks++;
        if (!ok || {q0_bitrate, q1_bitrate, q2_bitrate, q3_bitrate, total_bitrate} !==
            {32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, 32'd0, 32'hffff_ffff}) begin
            n_fail++;
            $display("FAIL sat3_rates got ok=%b q0=%h q1=%h q2=%h q3=%h tot=%h need ffffffff x3 0 ffffffff",
                     ok, q0_bitrate, q1_bitrate, q2_bitrate, q3_bitrate, total_bitrate);
        end
        do_reset();
        send_pkt(16'h0040, 16'd10, 1);
        wait_valid(100, ok);
        n_checks++;
        if (!ok || {q0_bitrate, q3_bitrate, total_bitrate} !==
            {32'd0, 32'd1_000_000_000, 32'd1_000_000_000}) begin
            n_fail++;
            $display("FAIL port3_rates got ok=%b q0=%0d q3=%0d tot=%0d need 0 1000000000 1000000000",
                     ok, q0_bitrate, q3_bitrate, total_bitrate);
        end
    endtask

    task automatic test_snapshot_boundary;
        sample_sel = 3'd2;
        do_reset();
        repeat (97) @(posedge clk);
        #1;
        send_pkt(16'h0001, 16'd64, 1);
        wait_valid(300, ok);
        n_checks++;
        if (!ok || cyc != 102 || {q0_bitrate, total_bitrate} !== '0) begin
            n_fail++;
            $display("FAIL edge_win0 got ok=%b cyc=%0d q0=%0d tot=%0d need cyc=102 q0=0 tot=0",
                     ok, cyc, q0_bitrate, total_bitrate);
        end
        @(posedge clk); #1;
        wait_valid(300, ok);
        n_checks++;
        if (!ok || cyc != 202 || {q0_bitrate, total_bitrate} !== {32'd640_000_000, 32'd640_000_000}) begin
            n_fail++;
            $display("FAIL edge_win1 got ok=%b cyc=%0d q0=%0d tot=%0d need cyc=202 q0=640000000 tot=640000000",
                     ok, cyc, q0_bitrate, total_bitrate);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp_data;
        logic [7:0]  exp_ctrl;
        int          seen;
        int          pass_bad;
        sample_sel = 3'd3;
        do_reset();
        seen = 0;
        pass_bad = 0;
        for (int p = 0; p < 5; p++) begin
            for (int w = 0; w < 4; w++) begin
                exp_ctrl = (w == 0) ? 8'hff : (w == 3) ? 8'h01 : 8'h00;
                exp_data = (w == 0) ? {16'h0001, 32'h0, 16'(10 * (p + 1))} : {32'(p), 32'(w) ^ 32'ha5a5};
                out_rdy  = ((p + w) % 2) == 1;
                in_data  = exp_data; in_ctrl = exp_ctrl; in_wr = 1'b1;
                #1;
                if (out_wr === 1'b1) seen++;
                if (out_data !== exp_data || out_ctrl !== exp_ctrl || out_wr !== 1'b1 ||
                    in_rdy !== out_rdy) pass_bad++;
                @(posedge clk); #1;
            end
        end
        in_wr = 1'b0; out_rdy = 1'b1;
        #1;
        n_checks++;
        if (pass_bad != 0 || seen != 20 || out_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_passthru got bad_words=%0d seen=%0d idle_wr=%b need 0 20 0", pass_bad, seen, out_wr);
        end
        repeat (480) @(posedge clk);
        #1;
        sample_sel = 3'd2;
        wait_valid(2000, ok);
        n_checks++;
        if (!ok || cyc != 1002 || {q0_bitrate, total_bitrate} !== {32'd150_000_000, 32'd150_000_000}) begin
            n_fail++;
            $display("FAIL b2b_win0 got ok=%b cyc=%0d q0=%0d tot=%0d need cyc=1002 150000000 150000000",
                     ok, cyc, q0_bitrate, total_bitrate);
        end
        @(posedge clk); #1;
        wait_valid(2000, ok);
        n_checks++;
        if (!ok || cyc != 1102 || {q0_bitrate, total_bitrate} !== '0) begin
            n_fail++;
            $display("FAIL b2b_win1 got ok=%b cyc=%0d q0=%0d tot=%0d need cyc=1102 0 0", ok, cyc, q0_bitrate, total_bitrate);
        end
        @(posedge clk); #1;
        wait_valid(2000, ok);
        n_checks++;
        if (!ok || cyc != 1202) begin
            n_fail++; $display("FAIL b2b_win2 got ok=%b cyc=%0d need cyc=1202", ok, cyc);
        end
    endtask

    task automatic test_reset_mid_packet;
        sample_sel = 3'd3;
        do_reset();
        send_pkt(16'h0001, 16'd100, 1);
        wait_valid(2000, ok);
        n_checks++;
        if (!ok || q0_bitrate !== 32'd100_000_000) begin
            n_fail++; $display("FAIL pre_reset_q0 got ok=%b q0=%0d need 100000000", ok, q0_bitrate);
        end
        @(posedge clk); #1;
        send_pkt(16'h0040, 16'd50, 1);
        send_word(8'hff, {16'h0004, 32'h0, 16'd200});
        send_word(8'h00, 64'h0);
        do_reset();
        n_checks++;
        if ({q0_bitrate, q1_bitrate, q2_bitrate, q3_bitrate, total_bitrate, rate_valid} !== '0) begin
            n_fail++;
            $display("FAIL midrst_values got q0=%0d q1=%0d q2=%0d q3=%0d tot=%0d rv=%b need all 0",
                     q0_bitrate, q1_bitrate, q2_bitrate, q3_bitrate, total_bitrate, rate_valid);
        end
        send_word(8'h01, 64'h0);
        send_pkt(16'h0010, 16'd70, 2);
        wait_valid(2000, ok);
        n_checks++;
        if (!ok || cyc != 1002 || {q0_bitrate, q1_bitrate, q2_bitrate, q3_bitrate, total_bitrate} !==
            {32'd0, 32'd0, 32'd70_000_000, 32'd0, 32'd70_000_000}) begin
            n_fail++;
            $display("FAIL midrst_rates got ok=%b cyc=%0d q0=%0d q1=%0d q2=%0d q3=%0d tot=%0d need cyc=1002 0 0 70000000 0 70000000",
                     ok, cyc, q0_bitrate, q1_bitrate, q2_bitrate, q3_bitrate, total_bitrate);
        end
    endtask

    initial begin
        in_data = '0; in_ctrl = '0; in_wr = 1'b0; out_rdy = 1'b1; sample_sel = 3'd3; reset = 1'b1;
        test_reset();
        test_unicast();
        test_multicast();
        test_saturation();
        test_snapshot_boundary();
        test_back_to_back();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/output_bitrate_meter.md
# output_bitrate_meter

Transparent datapath tap that sits at the tail of the user data path, just before the output queues. It measures the egress bitrate per MAC output port by parsing module headers and accumulating packet byte lengths. It is the egress counterpart of the input-side bitrate measurement: that block samples MAC-queue byte counters, while this one derives byte counts directly from packets leaving the pipeline. Per-port rates and a total rate are recomputed once per sampling window, with a one-cycle valid pulse.

## Interface
Parameters:
- DATA_WIDTH, 64, datapath word width.
- CTRL_WIDTH, DATA_WIDTH/8, control word width.
- IO_QUEUE_STAGE_NUM, 8'hff, in_ctrl value that marks the IO-queue module header.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, 125 MHz nominal.
- reset  in  1  synchronous, active-high.
- in_data  in  DATA_WIDTH  upstream data.
- in_ctrl  in  CTRL_WIDTH  upstream control.
- in_wr  in  1  upstream word valid; a word is accepted when in_wr=1.
- in_rdy  out  1  equals out_rdy (combinational).
- out_data  out  DATA_WIDTH  equals in_data (combinational).
- out_ctrl  out  CTRL_WIDTH  equals in_ctrl (combinational).
- out_wr  out  1  equals in_wr (combinational).
- out_rdy  in  1  downstream ready.
- sample_sel  in  3  window select: 1→10 cycles, 2→100, 3→1000, 4→10000, 5→100000, any other value→1000000.
- q0_bitrate..q3_bitrate  out  32 each  egress bit/s for MAC ports 0..3.
- total_bitrate  out  32  saturating sum of q0..q3.
- rate_valid  out  1  one-cycle pulse when all rate outputs update.

## Operation
- Datapath: pure pass-through with no added latency or backpressure. Monitoring never stalls traffic.
- Header format (word with in_ctrl==IO_QUEUE_STAGE_NUM):
  - [63:48] one-hot destination ports.
  - [15:0] byte length.
  - MAC port i corresponds to dst bit 2i (bits 0, 2, 4, 6).
  - Odd bits (CPU ports) and bits 8-15 are ignored.
- Parser FSM, states HDR and PAYLOAD. Reset state is HDR, with hdr_seen=0.
  - HDR, on an accepted word with in_ctrl≠0: if in_ctrl==IO_QUEUE_STAGE_NUM, latch dst and len and set hdr_seen=1. Any other nonzero ctrl word (other module headers) is ignored.
  - HDR, on an accepted word with in_ctrl==0: go to PAYLOAD.
  - PAYLOAD, on an accepted word with in_ctrl≠0 (EOP): for each i with hdr_seen=1 and dst bit 2i set, add len to acc_i. Then go to HDR and clear hdr_seen.
  - A packet without an IO-queue header is passed through but not counted.
  - Multicast headers add len to every selected port.
- Accumulators acc0..acc3 are 32 bits and saturate at 0xFFFFFFFF.
- Window FSM, states COUNT, MULT, SUM:
  - COUNT: cnt increments from 0. When cnt==period-1, snapshot acc_i into snap_i, clear acc_i, set cnt=0, and go to MULT.
  - The window period and scale are latched from sample_sel on the cycle cnt==0 of each COUNT window. A change to sample_sel mid-window takes effect in the next window.
  - MULT: q_i_bitrate ← min(snap_i × scale, 0xFFFFFFFF). Go to SUM.
  - SUM: total_bitrate ← saturating sum of the four q rates. Pulse rate_valid=1. Go to COUNT.
  - cnt keeps running during MULT and SUM: the window length is exactly period cycles, with no dead time.
- Scale values = 8 × 125e6 / period:
  - period 10 → 100,000,000
  - 100 → 10,000,000
  - 1000 → 1,000,000
  - 10000 → 100,000
  - 100000 → 10,000
  - 1000000 → 1,000
- Products are computed at ≥59 bits, then saturated to 32 bits.

## Timing
- Reset values: all rate outputs 0, rate_valid 0, accumulators 0, cnt 0, window FSM in COUNT, parser in HDR.
- The pass-through outputs follow their inputs combinationally and are unaffected by reset.
- The first window starts on the first cycle after reset deasserts. For period P, the snapshot occurs at cycle P-1 after that point.
- q_i_bitrate updates 1 cycle after the snapshot. total_bitrate and rate_valid follow 1 cycle later, and rate_valid is high for exactly 1 cycle.
- Between updates, all rate outputs hold their values.
- An EOP in the same cycle as the snapshot is not in the snapshot: its bytes go into the cleared accumulator for the next window.
- Reset mid-packet discards the partial packet. Reset mid-window discards the window; the outputs return to 0.

## Test plan
- sample_sel=3, one packet with dst 0x0004 and len 60, EOP inside window 0 → at the first rate_valid, q1=60,000,000, q0=q2=q3=0, total=60,000,000.
- sample_sel=3, one packet with dst 0x0005 and len 100 → q0=q1=100,000,000, total=200,000,000. A packet with dst 0x0002 (CPU only) → all rates 0.
- sample_sel=1, a 60-byte packet to port 0 → q0=0xFFFFFFFF. Three such packets to ports 0, 1, 2 → total=0xFFFFFFFF (saturated).
- sample_sel=2, EOP on cycle 99 (the snapshot cycle) → window 0 rates are all 0. Window 1 reports that packet: len 64 → q0=640,000,000.
- Back-to-back packets with out_rdy toggling → out_* equal in_*, in_rdy equals out_rdy, and no words are lost or duplicated. rate_valid pulses every 1000 cycles at sample_sel=3; changing sample_sel to 2 mid-window keeps the current window at 1000 cycles, and the following windows are 100 cycles.
- Assert reset for 1 cycle mid-packet and mid-window → outputs are 0 and the partial packet is not counted. The next full packet is counted normally in the first post-reset window.
